// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_pkg
//  Description : Shared ALU definitions for the serial arithmetic blocks.
//                Holds the sequencer state encoding and the default
//                operand width used by the serial adder/subtractor family.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    // Default operand/result width for the serial ALU blocks.
    localparam int C_DEFAULT_WIDTH = 8;

    // Sequencer states; the encodings are fixed and shared across blocks.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : One-bit full subtractor, the mirror of full_adder.
//                Computes a - b - bin.
//  Ports       : a, b, bin  - minuend bit, subtrahend bit, borrow in
//                diff, bout - difference bit, borrow out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // A borrow is needed when the minuend bit cannot cover b + bin.
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial subtractor computing a - b (mod 2^WIDTH), one
//                bit per clock, LSB first. A start accepted in IDLE or DONE
//                latches the operands; WIDTH SHIFT cycles later the block
//                spends one cycle in DONE with the new result on diff/borrow.
//  Parameters  : WIDTH  - operand/result width, 2..16
//  Ports       : clk    - clock, rising edge
//                rst    - synchronous active-high reset
//                start  - begin a subtraction (ignored while busy)
//                a, b   - minuend / subtrahend, sampled on accepted start
//                busy   - high while in SHIFT
//                done   - one-cycle pulse in DONE
//                diff   - last result a - b
//                borrow - high when a < b (unsigned) for the last result
//                zero   - diff == 0            (SERIAL_SUB_FLAGS_EN only)
//                ovf    - signed overflow      (SERIAL_SUB_FLAGS_EN only)
//  Config      : define SERIAL_SUB_FLAGS_EN to add the zero/ovf flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int              CW          = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   C_LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    // Partial result holds the WIDTH-1 difference bits produced so far; the
    // bit produced in the current cycle completes the word.
    logic [WIDTH-2:0] res_q,    res_d;
    logic             bin_q,    bin_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;

    logic             fs_diff;
    logic             fs_bout;
    logic [WIDTH-1:0] result_full;

`ifdef SERIAL_SUB_FLAGS_EN
    // Operand signs are captured at start because the shift registers lose
    // them long before the overflow flag is computed.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic zero_q,  zero_d;
    logic ovf_q,   ovf_d;
`endif

    full_subtractor u_full_subtractor (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (bin_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    assign result_full = {fs_diff, res_q};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_FLAGS_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_SHIFT;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_FLAGS_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            ST_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = result_full[WIDTH-1:1];
                bin_d  = fs_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == C_LAST_STEP) begin
                    state_d  = ST_DONE;
                    diff_d   = result_full;
                    borrow_d = fs_bout;
`ifdef SERIAL_SUB_FLAGS_EN
                    zero_d   = (result_full == '0);
                    ovf_d    = (a_msb_q ^ b_msb_q) & (result_full[WIDTH-1] ^ a_msb_q);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`endif

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (WIDTH = 8).
//                Vector table of operand pairs plus directed sequences for
//                start-while-busy, mid-operation reset and back-to-back use.
//                Honours SERIAL_SUB_FLAGS_EN for the zero/ovf outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_FLAGS_EN
    logic         zero;
    logic         ovf;
`endif

    serial_subtractor #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERIAL_SUB_FLAGS_EN
        .zero   (zero),
        .ovf    (ovf),
`endif
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] vd;
        logic         vbo;
        logic         vz;
        logic         vo;
    } vec_t;

    vec_t         vecs [6];
    int           n_total = 0;
    int           n_pass  = 0;
    logic [W-1:0] prev_diff   = '0;
    logic         prev_borrow = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Present operands with start, let the accepting edge pass, then drop
    // start and scramble the operand inputs. Returns at posedge + 1.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb);
        a     = ta;
        b     = tb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Watches cycles 1..W+1 after the accepting edge. Cycle c is the one
    // following the c-th edge after acceptance (sampled on the negedge).
    // glitch: cycle in which to pulse start with 0xFF/0xFF (0 = none).
    // chain : raise start with 0x03/0x07 in the last SHIFT cycle so it is
    //         present while in DONE.
    task automatic observe(input logic [W-1:0] ed, input logic eb, input logic ez,
                           input logic eo, input int glitch, input bit chain,
                           input string nm);
        int           first_done = 0;
        int           n_done     = 0;
        logic         hold_err   = 1'b0;
        logic         busy_err   = 1'b0;
        logic [W-1:0] gd         = '0;
        logic         gb         = 1'b0;
        logic         gz         = 1'b0;
        logic         go         = 1'b0;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = c;
                gd = diff;
                gb = borrow;
`ifdef SERIAL_SUB_FLAGS_EN
                gz = zero;
                go = ovf;
`endif
            end
            if (c <= W) begin
                if (diff !== prev_diff || borrow !== prev_borrow) hold_err = 1'b1;
                if (busy !== 1'b1) busy_err = 1'b1;
            end else if (busy !== 1'b0) begin
                busy_err = 1'b1;
            end
            if (glitch != 0 && c == glitch) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end
            if (glitch != 0 && c == glitch + 1) start = 1'b0;
            if (chain && c == W) begin
                start = 1'b1;
                a     = 8'h03;
                b     = 8'h07;
            end
        end
        check({nm, "_latency"}, first_done, W + 1);
        check({nm, "_ndone"},   n_done,     1);
        check({nm, "_diff"},    gd,         ed);
        check({nm, "_borrow"},  gb,         eb);
        check({nm, "_busy"},    busy_err,   0);
        check({nm, "_hold"},    hold_err,   0);
`ifdef SERIAL_SUB_FLAGS_EN
        check({nm, "_zero"},    gz,         ez);
        check({nm, "_ovf"},     go,         eo);
`else
        if (ez === 1'bx || eo === 1'bx) $display("note: unused flag expectation for %s", nm);
`endif
        prev_diff   = ed;
        prev_borrow = eb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           a      b      diff   bor   zero  ovf
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   busy,   0);
        check("reset_done",   done,   0);
        check("reset_diff",   diff,   0);
        check("reset_borrow", borrow, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].va, vecs[i].vb);
            observe(vecs[i].vd, vecs[i].vbo, vecs[i].vz, vecs[i].vo, 0, 1'b0,
                    $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
        end

        // Start pulsed while busy must be ignored.
        launch(8'h10, 8'h01);
        observe(8'h0F, 1'b0, 1'b0, 1'b0, 3, 1'b0, "ignore");
        @(negedge clk);
        check("ignore_idle_busy", busy, 0);
        check("ignore_idle_done", done, 0);
        @(posedge clk);
        #1;

        // Reset four cycles into an operation aborts it without a done.
        begin
            int n_done = 0;
            launch(8'h20, 8'h01);
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check("abort_busy",   busy,   0);
            check("abort_done",   done,   0);
            check("abort_diff",   diff,   0);
            check("abort_borrow", borrow, 0);
            for (int c = 0; c < W + 2; c++) begin
                if (done === 1'b1) n_done++;
                @(negedge clk);
            end
            check("abort_nodone", n_done, 0);
            prev_diff   = '0;
            prev_borrow = 1'b0;
            @(posedge clk);
            #1;
        end
        launch(8'h09, 8'h04);
        observe(8'h05, 1'b0, 1'b0, 1'b0, 0, 1'b0, "after_abort");
        @(posedge clk);
        #1;

        // Back-to-back: start held high through DONE.
        launch(8'h40, 8'h10);
        observe(8'h30, 1'b0, 1'b0, 1'b0, 0, 1'b1, "b2b_first");
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        observe(8'hFC, 1'b1, 1'b0, 1'b0, 0, 1'b0, "b2b_second");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits; legal range is 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a subtraction.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each, the minuend and subtrahend, sampled only on an accepted start.
REQ-006 The block SHALL have port busy, output, 1 bit, high while a subtraction is in progress.
REQ-007 The block SHALL have port done, output, 1 bit, a one-cycle pulse when the result is valid.
REQ-008 The block SHALL have port diff, output, WIDTH bits, the result a-b modulo 2^WIDTH.
REQ-009 The block SHALL have port borrow, output, 1 bit, high when a<b unsigned.

Function
REQ-010 The block SHALL use an FSM with the states IDLE, SHIFT and DONE.
REQ-011 In IDLE or DONE, a start sampled high SHALL latch a and b into shift registers, clear the internal borrow and the bit counter, and enter SHIFT.
REQ-012 In SHIFT, the block SHALL run one full-subtractor step per cycle, LSB first: the difference bit shifts into the result MSB and the borrow-out is registered as the next borrow-in.
REQ-013 After exactly WIDTH SHIFT cycles, the block SHALL enter DONE and transfer the result to diff and the final borrow to borrow.
REQ-014 Latency SHALL be fixed: done is high in the cycle WIDTH+1 clocks after the edge that accepted start.
REQ-015 done SHALL be high only in DONE, which lasts one cycle; DONE SHALL then go to IDLE unless start is high, in which case it goes to SHIFT (back-to-back operation).
REQ-016 busy SHALL be high only in SHIFT.
REQ-017 start SHALL be ignored while busy, and a and b changing during SHIFT SHALL NOT affect the result.
REQ-018 diff and borrow SHALL hold their last result until the next DONE, and SHALL NOT change during a following SHIFT.
REQ-019 Borrow arithmetic: the borrow-in to bit 0 SHALL be 0, and borrow SHALL be the borrow out of bit WIDTH-1.

Reset
REQ-020 When rst is high at a clock edge, the block SHALL enter IDLE and clear busy, done, diff, borrow, the counter and the internal registers; this takes priority over start.
REQ-021 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL behave normally.

Configuration
REQ-022 With macro SERIAL_SUB_FLAGS_EN defined, the block SHALL add outputs zero (diff==0) and ovf (signed overflow: a[MSB]!=b[MSB] and diff[MSB]!=a[MSB]), registered and updated with diff, and reset to 0.
REQ-023 Without SERIAL_SUB_FLAGS_EN, the zero and ovf ports and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-024 The FSM state encodings (IDLE=0, SHIFT=1, DONE=2) and the default width constant SHALL live in the shared ALU package/header used by the adder blocks.
REQ-025 The block SHALL instantiate one sub-module, full_subtractor (a, b, bin -> diff, bout), as the mirror of the existing full_adder.
REQ-026 The counter SHALL be sized to $clog2(WIDTH+1) bits.

Verification
REQ-027 A bench SHALL check a=0x05, b=0x03, start pulse -> done 9 clocks later, diff=0x02, borrow=0 (and zero=0, ovf=0 when FLAGS are enabled).
REQ-028 A bench SHALL check a=0x00, b=0x01 -> diff=0xFF, borrow=1 (and ovf=0).
REQ-029 A bench SHALL check a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1; and a=0x5A, b=0x5A -> diff=0x00, zero=1.
REQ-030 A bench SHALL check a=0x10, b=0x01 accepted, then start pulsed with a=0xFF, b=0xFF at cycle 3 -> the second start is ignored and diff=0x0F with a single done.
REQ-031 A bench SHALL check rst asserted 4 cycles into an operation -> busy=0, diff=0x00 next cycle and no done; a new start with a=0x09, b=0x04 -> diff=0x05.
REQ-032 A bench SHALL check start held high during DONE with a=0x03, b=0x07 -> busy the next cycle and diff=0xFC, borrow=1 after WIDTH+1 clocks.
